sap1_control_sequencer: RTL

- T-state ring counter and microcode decoder for the SAP-1 datapath.
- Sequences the instruction register (load from bus, send address to bus), program counter, MAR/RAM, A/B registers, ALU and output register through fetch (T1-T3) and execute (T4-T6).
- Decodes the 4-bit opcode presented by the instruction register.
- Supports free-run, single-step and halt.

---
 rtl/sap1_pkg.sv | 49 ++++
 rtl/sap1_ring_counter.sv | 32 +++
 rtl/sap1_control_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 opcodes, one-hot T-state encodings and the control-word layout
// used by the sequencer and the datapath top level.
package sap1_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned TS_W = 6;

  localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  localparam logic [TS_W-1:0] T1 = 6'b000001;
  localparam logic [TS_W-1:0] T2 = 6'b000010;
  localparam logic [TS_W-1:0] T3 = 6'b000100;
  localparam logic [TS_W-1:0] T4 = 6'b001000;
  localparam logic [TS_W-1:0] T5 = 6'b010000;
  localparam logic [TS_W-1:0] T6 = 6'b100000;

  typedef struct packed {
    logic pc_inc;
    logic pc_out;
    logic mar_load;
    logic ram_out;
    logic instr_load_in;
    logic instr_send_in;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_sub;
    logic alu_out;
    logic out_load;
  } ctrl_word_t;

  localparam int unsigned CTRL_W = $bits(ctrl_word_t);

  typedef enum logic {
    SEQ_RUN  = 1'b0,
    SEQ_HALT = 1'b1
  } seq_state_e;

  // Any opcode without execute micro-steps (HLT is handled separately).
  function automatic logic is_nop(input logic [OP_W-1:0] op);
    return !(op == OP_LDA || op == OP_ADD || op == OP_SUB ||
             op == OP_OUT || op == OP_HLT);
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring counter with hold, advance and restart-to-T1 controls.
module sap1_ring_counter #(
  parameter int unsigned N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic         restart,
  output logic [N-1:0] state
);

  logic [N-1:0] state_nxt;

  // Restart wins over rotate; neither means hold.
  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = N'(1);
    end else if (advance) begin
      state_nxt = {state[N-2:0], state[N-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= N'(1);
    end else begin
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: T-state ring plus microcode decode of the IR opcode,
// with free-run, single-step and halt.
module sap1_control_sequencer
  import sap1_pkg::*;
#(
  parameter int unsigned T_STATES  = 6,
  parameter bit          EARLY_END = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            step,
  input  logic [OP_W-1:0] opcode_in,
  output logic            pc_inc,
  output logic            pc_out,
  output logic            mar_load,
  output logic            ram_out,
  output logic            instr_load_in,
  output logic            instr_send_in,
  output logic            a_load,
  output logic            a_out,
  output logic            b_load,
  output logic            alu_sub,
  output logic            alu_out,
  output logic            out_load,
  output logic            halted,
  output logic [TS_W-1:0] t_state
);

  seq_state_e seq_state;
  seq_state_e seq_state_nxt;
  ctrl_word_t ustep_c;
  ctrl_word_t ctrl_c;
  logic       last_step_c;
  logic       adv_c;
  logic       ring_adv_c;
  logic       ring_restart_c;

  assign adv_c = run | step;

  sap1_ring_counter #(
    .N (T_STATES)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .advance (ring_adv_c),
    .restart (ring_restart_c),
    .state   (t_state)
  );

  // Microcode ROM: control word and last-micro-step flag for (T-state, opcode).
  // NOP is recognised in T3 only so the early-end path can leave right after fetch.
  always_comb begin
    ustep_c     = '0;
    last_step_c = 1'b0;
    case (t_state)
      T1: begin
        ustep_c.pc_out   = 1'b1;
        ustep_c.mar_load = 1'b1;
      end
      T2: ustep_c.pc_inc = 1'b1;
      T3: begin
        ustep_c.ram_out       = 1'b1;
        ustep_c.instr_load_in = 1'b1;
        last_step_c           = is_nop(opcode_in);
      end
      T4: begin
        case (opcode_in)
          OP_LDA, OP_ADD, OP_SUB: begin
            ustep_c.instr_send_in = 1'b1;
            ustep_c.mar_load      = 1'b1;
          end
          OP_OUT: begin
            ustep_c.a_out    = 1'b1;
            ustep_c.out_load = 1'b1;
            last_step_c      = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (opcode_in)
          OP_LDA: begin
            ustep_c.ram_out = 1'b1;
            ustep_c.a_load  = 1'b1;
            last_step_c     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ustep_c.ram_out = 1'b1;
            ustep_c.b_load  = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        if (opcode_in == OP_ADD || opcode_in == OP_SUB) begin
          ustep_c.alu_out = 1'b1;
          ustep_c.a_load  = 1'b1;
          ustep_c.alu_sub = (opcode_in == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seq_state <= SEQ_RUN;
    end else begin
      seq_state <= seq_state_nxt;
    end
  end

  // Run/halt control: gates the microcode and steers the ring counter.
  always_comb begin
    seq_state_nxt  = seq_state;
    ctrl_c         = '0;
    ring_adv_c     = 1'b0;
    ring_restart_c = 1'b0;
    if (seq_state == SEQ_RUN && adv_c) begin
      ctrl_c = ustep_c;
      if (t_state == T4 && opcode_in == OP_HLT) begin
        seq_state_nxt = SEQ_HALT;
      end else if (EARLY_END && last_step_c) begin
        ring_restart_c = 1'b1;
      end else begin
        ring_adv_c = 1'b1;
      end
    end
    if (!rst) begin
      ctrl_c = '0;
    end
  end

  assign halted        = (seq_state == SEQ_HALT);
  assign pc_inc        = ctrl_c.pc_inc;
  assign pc_out        = ctrl_c.pc_out;
  assign mar_load      = ctrl_c.mar_load;
  assign ram_out       = ctrl_c.ram_out;
  assign instr_load_in = ctrl_c.instr_load_in;
  assign instr_send_in = ctrl_c.instr_send_in;
  assign a_load        = ctrl_c.a_load;
  assign a_out         = ctrl_c.a_out;
  assign b_load        = ctrl_c.b_load;
  assign alu_sub       = ctrl_c.alu_sub;
  assign alu_out       = ctrl_c.alu_out;
  assign out_load      = ctrl_c.out_load;

endmodule
